// File: rtl/mc_ctrl_fsm_if.sv
// Bundle of the IR fields, ALU status flags and control outputs exchanged
// between the multi-cycle datapath (master) and its control FSM (slave).
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       zero;
  logic       overflow;
  logic       nCondition;
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic       MemWr;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic       write_30;
  logic [1:0] ExtOp;
  logic [1:0] NPCOp;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct, rt, zero, overflow, nCondition,
    input  PCWr, IRWr, RegWr, MemWr, ALUSrc, ALUOp, write_30, ExtOp,
           NPCOp, RegDst, MemtoReg, illegal, state
  );

  modport slave (
    input  op, funct, rt, zero, overflow, nCondition,
    output PCWr, IRWr, RegWr, MemWr, ALUSrc, ALUOp, write_30, ExtOp,
           NPCOp, RegDst, MemtoReg, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit: decodes the IR fields and walks
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, driving ALU, extender, next-PC and
// write-enable controls combinationally from the current state.
module mc_ctrl_fsm (
  input  logic         clk,
  input  logic         reset,
  mc_ctrl_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MA     = 4'd2,
    S_MR     = 4'd3,
    S_MWB    = 4'd4,
    S_MW     = 4'd5,
    S_EXE    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic       is_r, is_addu, is_subu, is_slt, is_jr;
  logic       is_ori, is_lui, is_addi, is_lw, is_sw;
  logic       is_beq, is_bgezal, is_j, is_jal;
  logic       is_mem, is_alu, is_br, is_jmp;

  logic       exe_alu_src, exe_write_30;
  logic [1:0] exe_alu_op, exe_ext_op;

  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src, write_30, illegal;
  logic [1:0] alu_op, ext_op, npc_op, reg_dst, mem_to_reg;

  assign is_r      = (bus.op == 6'b000000);
  assign is_addu   = is_r && (bus.funct == 6'b100001);
  assign is_subu   = is_r && (bus.funct == 6'b100011);
  assign is_slt    = is_r && (bus.funct == 6'b101010);
  assign is_jr     = is_r && (bus.funct == 6'b001000);
  assign is_ori    = (bus.op == 6'b001101);
  assign is_lui    = (bus.op == 6'b001111);
  assign is_addi   = (bus.op == 6'b001000);
  assign is_lw     = (bus.op == 6'b100011);
  assign is_sw     = (bus.op == 6'b101011);
  assign is_beq    = (bus.op == 6'b000100);
  assign is_bgezal = (bus.op == 6'b000001) && (bus.rt == 5'b10001);
  assign is_j      = (bus.op == 6'b000010);
  assign is_jal    = (bus.op == 6'b000011);

  assign is_mem = is_lw | is_sw;
  assign is_alu = is_addu | is_subu | is_slt | is_ori | is_lui | is_addi;
  assign is_br  = is_beq | is_bgezal;
  assign is_jmp = is_j | is_jal | is_jr;

  // State register; reset drops straight back to FETCH without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection; any undefined encoding falls back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem)      state_d = S_MA;
        else if (is_alu) state_d = S_EXE;
        else if (is_br)  state_d = S_BR;
        else if (is_jmp) state_d = S_JMP;
        else             state_d = S_FETCH;
      end
      S_MA:     state_d = is_lw ? S_MR : S_MW;
      S_MR:     state_d = S_MWB;
      S_EXE:    state_d = S_RWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // ALU setup shared by EXE and RWB so the result stays stable through writeback
  always_comb begin
    exe_alu_op   = 2'b00;
    exe_alu_src  = 1'b0;
    exe_ext_op   = 2'b00;
    exe_write_30 = 1'b0;
    if (is_subu) exe_alu_op = 2'b01;
    if (is_slt)  exe_alu_op = 2'b11;
    if (is_ori) begin
      exe_alu_op  = 2'b10;
      exe_alu_src = 1'b1;
    end
    if (is_lui) begin
      exe_alu_op  = 2'b10;
      exe_alu_src = 1'b1;
      exe_ext_op  = 2'b10;
    end
    if (is_addi) begin
      exe_alu_src  = 1'b1;
      exe_ext_op   = 2'b01;
      exe_write_30 = 1'b1;
    end
  end

  // Per-state control outputs; write enables and illegal are masked during reset
  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    write_30   = 1'b0;
    ext_op     = 2'b00;
    npc_op     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_wr = 1'b1;
        ir_wr = 1'b1;
      end
      S_DECODE: illegal = ~(is_mem | is_alu | is_br | is_jmp);
      S_MA: begin
        alu_src = 1'b1;
        ext_op  = 2'b01;
      end
      S_MWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MW: begin
        mem_wr  = 1'b1;
        alu_src = 1'b1;
        ext_op  = 2'b01;
      end
      S_EXE: begin
        alu_op   = exe_alu_op;
        alu_src  = exe_alu_src;
        ext_op   = exe_ext_op;
        write_30 = exe_write_30;
      end
      S_RWB: begin
        alu_op   = exe_alu_op;
        alu_src  = exe_alu_src;
        ext_op   = exe_ext_op;
        write_30 = exe_write_30;
        reg_wr   = 1'b1;
        reg_dst  = is_r ? 2'b01 : 2'b00;
        if (is_addi && bus.overflow) begin
          reg_dst    = 2'b11;
          mem_to_reg = 2'b11;
        end
      end
      S_BR: begin
        npc_op = 2'b01;
        if (is_beq) begin
          alu_op = 2'b01;
          pc_wr  = bus.zero;
        end else if (is_bgezal) begin
          pc_wr      = ~bus.nCondition;
          reg_wr     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      S_JMP: begin
        pc_wr  = 1'b1;
        npc_op = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      default: ;
    endcase
    if (reset) begin
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      illegal = 1'b0;
    end
  end

  assign bus.PCWr     = pc_wr;
  assign bus.IRWr     = ir_wr;
  assign bus.RegWr    = reg_wr;
  assign bus.MemWr    = mem_wr;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUOp    = alu_op;
  assign bus.write_30 = write_30;
  assign bus.ExtOp    = ext_op;
  assign bus.NPCOp    = npc_op;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.illegal  = illegal;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each issued instruction pushes its
// expected per-cycle control vector sequence; a negedge monitor pops and
// compares one vector per clock.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_fsm_if bus();

  mc_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  typedef enum int {
    K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI, K_ADDI, K_LW,
    K_SW, K_BEQ, K_BGEZAL, K_J, K_JAL, K_JR, K_ILL
  } kind_e;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       w30;
    logic [1:0] ext_op;
    logic [1:0] npc_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       ill;
  } out_t;

  out_t exp_q[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  bit   running = 1'b1;

  function automatic out_t rec(input logic [3:0] st);
    out_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o.st         = bus.state;
    o.pc_wr      = bus.PCWr;
    o.ir_wr      = bus.IRWr;
    o.reg_wr     = bus.RegWr;
    o.mem_wr     = bus.MemWr;
    o.alu_src    = bus.ALUSrc;
    o.alu_op     = bus.ALUOp;
    o.w30        = bus.write_30;
    o.ext_op     = bus.ExtOp;
    o.npc_op     = bus.NPCOp;
    o.reg_dst    = bus.RegDst;
    o.mem_to_reg = bus.MemtoReg;
    o.ill        = bus.illegal;
    return o;
  endfunction

  // Reference: the full cycle-by-cycle control sequence of one instruction,
  // flags given per cycle of the instruction (index 0 = FETCH)
  function automatic int build_expected(input kind_e k, input bit [4:0] zv,
                                        input bit [4:0] ov, input bit [4:0] nv);
    out_t o;
    int   n0;
    bit   r_type;
    n0     = exp_q.size();
    r_type = (k == K_ADDU) || (k == K_SUBU) || (k == K_SLT);
    o = rec(4'd0); o.pc_wr = 1'b1; o.ir_wr = 1'b1; exp_q.push_back(o);
    o = rec(4'd1); o.ill = (k == K_ILL); exp_q.push_back(o);
    case (k)
      K_LW, K_SW: begin
        o = rec(4'd2); o.alu_src = 1'b1; o.ext_op = 2'b01; exp_q.push_back(o);
        if (k == K_LW) begin
          exp_q.push_back(rec(4'd3));
          o = rec(4'd4); o.reg_wr = 1'b1; o.mem_to_reg = 2'b01; exp_q.push_back(o);
        end else begin
          o = rec(4'd5); o.mem_wr = 1'b1; o.alu_src = 1'b1; o.ext_op = 2'b01;
          exp_q.push_back(o);
        end
      end
      K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI, K_ADDI: begin
        o = rec(4'd6);
        case (k)
          K_SUBU: o.alu_op = 2'b01;
          K_SLT:  o.alu_op = 2'b11;
          K_ORI:  begin o.alu_op = 2'b10; o.alu_src = 1'b1; end
          K_LUI:  begin o.alu_op = 2'b10; o.alu_src = 1'b1; o.ext_op = 2'b10; end
          K_ADDI: begin o.alu_src = 1'b1; o.ext_op = 2'b01; o.w30 = 1'b1; end
          default: ;
        endcase
        exp_q.push_back(o);
        o.st      = 4'd7;
        o.reg_wr  = 1'b1;
        o.reg_dst = r_type ? 2'b01 : 2'b00;
        if (k == K_ADDI && ov[3]) begin
          o.reg_dst    = 2'b11;
          o.mem_to_reg = 2'b11;
        end
        exp_q.push_back(o);
      end
      K_BEQ: begin
        o = rec(4'd8); o.alu_op = 2'b01; o.npc_op = 2'b01; o.pc_wr = zv[2];
        exp_q.push_back(o);
      end
      K_BGEZAL: begin
        o = rec(4'd8); o.npc_op = 2'b01; o.pc_wr = ~nv[2];
        o.reg_wr = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
        exp_q.push_back(o);
      end
      K_J, K_JAL, K_JR: begin
        o = rec(4'd9); o.pc_wr = 1'b1;
        o.npc_op = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin
          o.reg_wr = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
        end
        exp_q.push_back(o);
      end
      default: ;
    endcase
    return exp_q.size() - n0;
  endfunction

  task automatic check_output(input string name, input out_t got, input out_t want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h (state %0d) expected %h (state %0d)",
               name, $time, got, got.st, want, want.st);
    end
  endtask

  // Load IR fields for one instruction kind, randomising don't-care fields
  task automatic encode(input kind_e k);
    bus.funct = 6'($urandom);
    bus.rt    = 5'($urandom);
    case (k)
      K_ADDU:   begin bus.op = 6'b000000; bus.funct = 6'b100001; end
      K_SUBU:   begin bus.op = 6'b000000; bus.funct = 6'b100011; end
      K_SLT:    begin bus.op = 6'b000000; bus.funct = 6'b101010; end
      K_JR:     begin bus.op = 6'b000000; bus.funct = 6'b001000; end
      K_ORI:    bus.op = 6'b001101;
      K_LUI:    bus.op = 6'b001111;
      K_ADDI:   bus.op = 6'b001000;
      K_LW:     bus.op = 6'b100011;
      K_SW:     bus.op = 6'b101011;
      K_BEQ:    bus.op = 6'b000100;
      K_BGEZAL: begin bus.op = 6'b000001; bus.rt = 5'b10001; end
      K_J:      bus.op = 6'b000010;
      K_JAL:    bus.op = 6'b000011;
      default: begin
        case ($urandom_range(0, 7))
          0: bus.op = 6'b111111;
          1: bus.op = 6'b000101;
          2: bus.op = 6'b001010;
          3: bus.op = 6'b100000;
          4: begin bus.op = 6'b000000; bus.funct = 6'b100000; end
          5: begin bus.op = 6'b000000; bus.funct = 6'b100100; end
          6: begin bus.op = 6'b000001; bus.rt = 5'b00000; end
          default: begin bus.op = 6'b000001; bus.rt = 5'b10000; end
        endcase
      end
    endcase
  endtask

  // Issue one instruction starting in a FETCH cycle (called just after a posedge)
  task automatic apply_stimulus(input kind_e k, input bit force_flags,
                                input bit fz, input bit fo, input bit fn);
    bit [4:0] zv, ov, nv;
    int n;
    encode(k);
    if (force_flags) begin
      zv = {5{fz}}; ov = {5{fo}}; nv = {5{fn}};
    end else begin
      zv = 5'($urandom); ov = 5'($urandom); nv = 5'($urandom);
    end
    n = build_expected(k, zv, ov, nv);
    for (int c = 0; c < n; c++) begin
      bus.zero       = zv[c];
      bus.overflow   = ov[c];
      bus.nCondition = nv[c];
      @(posedge clk);
      #1;
    end
  endtask

  // Reset arrives asynchronously while a lw sits in MR
  task automatic reset_mid_lw();
    int n;
    out_t discard;
    encode(K_LW);
    n = build_expected(K_LW, 5'b0, 5'b0, 5'b0);
    discard = exp_q.pop_back();
    discard = exp_q.pop_back();
    for (int c = 0; c < n - 2; c++) begin
      @(posedge clk);
      #1;
    end
    #1 reset = 1'b1;
    #1 check_output("async_reset", actual(), rec(4'd0));
    exp_q.push_back(rec(4'd0));
    @(posedge clk);
    #1;
    exp_q.push_back(rec(4'd0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: one expected vector per clock, sampled mid-cycle
  always @(negedge clk) begin
    if (running) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL underflow at %0t: got %h expected none", $time, actual());
      end else begin
        check_output("cycle", actual(), exp_q.pop_front());
      end
    end
  end

  // Bound on total run time
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed instructions, random stream, async reset
  initial begin
    reset          = 1'b1;
    bus.op         = 6'b0;
    bus.funct      = 6'b0;
    bus.rt         = 5'b0;
    bus.zero       = 1'b0;
    bus.overflow   = 1'b0;
    bus.nCondition = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rec(4'd0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    apply_stimulus(K_ADDU,   1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_LW,     1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_SW,     1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_BEQ,    1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(K_BEQ,    1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_BGEZAL, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(K_BGEZAL, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_ADDI,   1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(K_ADDI,   1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_ILL,    1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_JR,     1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_J,      1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_JAL,    1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(K_SUBU,   1'b1, 1'b1, 1'b1, 1'b1);
    apply_stimulus(K_SLT,    1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(K_ORI,    1'b1, 1'b1, 1'b0, 1'b1);
    apply_stimulus(K_LUI,    1'b1, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(kind_e'($urandom_range(0, 13)), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    reset_mid_lw();
    apply_stimulus(K_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);

    running = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL leftover: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit for the processor datapath. Decodes the instruction held in the IR and steps through the FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. Each cycle it drives the ALU controls (ALUOp, ALUSrc, write_30), the extender mode, the next-PC mode and every register/memory write enable. It samples the ALU status flags (zero, overflow, nCondition) to resolve branches and the addi overflow write to $30.

## Interface
- No parameters; opcode/funct encodings are fixed MIPS values.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rt  in  5  IR[20:16]; selects bgezal (10001) under op 000001
- zero, overflow, nCondition  in  1 each  ALU status
- PCWr, IRWr, RegWr, MemWr  out  1 each  write enables
- ALUSrc  out  1  0 = register B, 1 = ext32
- ALUOp  out  2  00 add, 01 sub, 10 or, 11 slt
- write_30  out  1  enables the ALU overflow output (addi only)
- ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- NPCOp  out  2  00 PC+4, 01 branch, 10 j/jal, 11 jr
- RegDst  out  2  00 rt, 01 rd, 10 $31, 11 $30
- MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4, 11 constant 1
- illegal  out  1  one-cycle pulse on an undecodable instruction
- state  out  4  current state, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MA 2, MR 3, MWB 4, MW 5, EXE 6, RWB 7, BR 8, JMP 9.
- Encodings 10–15 are unreachable; if entered, return to FETCH.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state DECODE.
- DECODE dispatch:
  - lw/sw: MA.
  - R-type addu/subu/slt, ori, lui, addi: EXE.
  - beq, bgezal: BR.
  - j, jal, jr (R-type funct 001000): JMP.
  - Anything else: illegal=1, no writes, next state FETCH.
- MA: ALUOp=00, ALUSrc=1, ExtOp=01. lw goes to MR, sw goes to MW.
- MR then MWB. In MWB: RegWr=1, RegDst=00, MemtoReg=01. Then FETCH.
- MW: MemWr=1 with the same ALU controls as MA. Then FETCH.
- EXE ALU controls, held unchanged through RWB:
  - addu: ALUOp 00.
  - subu: ALUOp 01.
  - slt: ALUOp 11.
  - ori: ALUOp 10, ALUSrc 1, ExtOp 00.
  - lui: ALUOp 10, ALUSrc 1, ExtOp 10. Operand A is $0 by instruction format.
  - addi: ALUOp 00, ALUSrc 1, ExtOp 01, write_30=1.
- RWB: RegWr=1, MemtoReg=00. RegDst=01 for R-type, 00 for I-type.
  - addi with overflow=1 in RWB: RegDst=11, MemtoReg=11 ($30 ← 1). The rt write is suppressed.
  - Next state FETCH.
- BR, beq: ALUOp=01, ALUSrc=0, NPCOp=01, PCWr=zero.
- BR, bgezal: NPCOp=01, PCWr=~nCondition. RegWr=1, RegDst=10, MemtoReg=10; the link is written unconditionally.
- JMP: PCWr=1. NPCOp=10 for j/jal, 11 for jr. jal also asserts RegWr=1, RegDst=10, MemtoReg=10.
- Any signal not listed for a state is 0.

## Timing
- state is a register with asynchronous reset.
  - Reset asserted: state=FETCH immediately, regardless of clk.
  - All write enables (PCWr, IRWr, RegWr, MemWr) and illegal are forced to 0 combinationally while reset=1.
  - Every other output holds its FETCH value (all 0).
- First FETCH writes occur on the first rising edge after reset deasserts.
- Outputs are combinational from state, op, funct, rt and the ALU flags; there are no extra pipeline registers.
- op, funct and rt are stable from DECODE to the end of the instruction, because IRWr is asserted only in FETCH.
- ALU flags are evaluated in the same cycle as the state that uses them (RWB, BR). Operands are stable because the A/B/ALUOut registers are datapath-owned.
- Cycle counts per instruction:
  - lw: 5
  - R-type, ori, lui, addi, sw: 4
  - beq, bgezal, j, jal, jr: 3
  - illegal: 2
- Reset asserted mid-instruction aborts it; no partial write occurs after reset rises.

## Test plan
- Reset held 3 cycles, then released, with IR=addu → state 0,1,6,7,0. RegWr=1 only in cycle 4 with RegDst=01. PCWr/IRWr=1 only in cycle 1.
- lw → states 0,1,2,3,4. In state 2: ALUOp=00, ALUSrc=1, ExtOp=01. In state 4: RegWr=1, MemtoReg=01. sw → MemWr=1 only in state 5.
- beq with zero=1 → PCWr=1 in BR. With zero=0 → PCWr=0. bgezal with nCondition=1 → PCWr=0, RegWr=1, RegDst=10.
- addi with overflow forced to 1 in RWB → RegDst=11, MemtoReg=11, write_30=1. With overflow=0 → RegDst=00, MemtoReg=00.
- op=111111 → illegal=1 in DECODE, no enables asserted, FETCH next. jr (op 0, funct 001000) → JMP with NPCOp=11.
- reset asserted asynchronously in MR of lw → state=0 and all enables 0 within the same cycle, before the next clk edge.
